// File: rtl/eth_stream_mux.sv
// eth_stream_mux
//   Merges NCH packet streams into one stream towards the MAC tx FIFO.
//   Each input channel feeds a show-ahead FIFO of 2**DEPTH_LOG2 beats.
//   A two-state arbiter grants whole packets round-robin. Between packets it
//   discards beats that arrive without a start-of-packet (orphans).
//
// Parameters
//   DATA_W      stream data width
//   MOD_W       empty-byte modulo width (valid on the last beat)
//   NCH         number of input channels (2..8)
//   DEPTH_LOG2  log2 of per-channel FIFO depth
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_data/i_mod               packed per-channel data/modulo (channel k at k*W)
//   i_sop/i_eop/i_vld, o_rdy   per-channel framing, valid and ready (FIFO not full)
//   o_data/o_mod/o_sop/o_eop   merged stream
//   o_vld, i_rdy               merged valid and sink ready
//   o_grant                    one-hot channel being forwarded, zero when idle
//   o_drop                     per-channel pulse for each discarded orphan beat
//   o_frame_cnt                per-channel forwarded-frame counters (16 bits each)
//
// Build option
//   ETH_STREAM_MUX_STAT_EN  when defined, o_frame_cnt counts forwarded frames;
//                           otherwise it is tied to zero and has no flops.
module eth_stream_mux #(
  parameter int DATA_W     = 32,
  parameter int MOD_W      = 2,
  parameter int NCH        = 2,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*DATA_W-1:0] i_data,
  input  logic [NCH*MOD_W-1:0]  i_mod,
  input  logic [NCH-1:0]        i_sop,
  input  logic [NCH-1:0]        i_eop,
  input  logic [NCH-1:0]        i_vld,
  output logic [NCH-1:0]        o_rdy,
  output logic [DATA_W-1:0]     o_data,
  output logic [MOD_W-1:0]      o_mod,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [NCH-1:0]        o_grant,
  output logic [NCH-1:0]        o_drop,
  output logic [NCH*16-1:0]     o_frame_cnt
);

  localparam int ENT_W = DATA_W + MOD_W + 2;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  typedef enum logic {IDLE, FWD} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  logic [NCH-1:0]   wr_en;
  logic [NCH-1:0]   pop;
  logic [NCH-1:0]   not_empty;
  logic [NCH-1:0]   head_sop;
  logic [NCH-1:0]   head_eop;
  logic [ENT_W-1:0] head [NCH];
  logic [ENT_W-1:0] sel_head;
  logic             fwd;

  // Per-channel show-ahead FIFO: entry = {data, mod, sop, eop}
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [ENT_W-1:0]      mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   cnt;

    // Ready is pure occupancy, so a full FIFO stays not-ready in the cycle it is popped.
    assign o_rdy[k]     = (cnt != FULL_CNT);
    assign wr_en[k]     = i_vld[k] & o_rdy[k];
    assign not_empty[k] = (cnt != '0);
    assign head[k]      = mem[rd_ptr];
    assign head_sop[k]  = head[k][1];
    assign head_eop[k]  = head[k][0];

    always_ff @(posedge clk) begin
      if (wr_en[k]) begin
        mem[wr_ptr] <= {i_data[k*DATA_W +: DATA_W], i_mod[k*MOD_W +: MOD_W], i_sop[k], i_eop[k]};
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr_en[k]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[k])   rd_ptr <= rd_ptr + 1'b1;
        case ({wr_en[k], pop[k]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Arbiter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NCH-1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    pop     = '0;
    o_drop  = '0;
    found   = 1'b0;
    cand    = '0;
    case (state_q)
      IDLE: begin
        // Round-robin search beginning just after the last served channel.
        for (int i = 1; i <= NCH; i++) begin
          cand = IDX_W'((int'(last_q) + i) % NCH);
          if (!found && not_empty[cand] && head_sop[cand]) begin
            found   = 1'b1;
            grant_d = cand;
            state_d = FWD;
          end
        end
        // Orphans drain one beat per cycle on every affected channel in parallel.
        for (int k = 0; k < NCH; k++) begin
          if (not_empty[k] && !head_sop[k]) begin
            pop[k]    = 1'b1;
            o_drop[k] = 1'b1;
          end
        end
      end
      FWD: begin
        if (not_empty[grant_q] && i_rdy) begin
          pop[grant_q] = 1'b1;
          if (head_eop[grant_q]) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Merged output: head of the granted FIFO, forced to zero while idle
  assign fwd      = (state_q == FWD);
  assign sel_head = head[grant_q];
  assign o_vld    = fwd & not_empty[grant_q];
  assign o_data   = fwd ? sel_head[ENT_W-1 -: DATA_W] : '0;
  assign o_mod    = fwd ? sel_head[MOD_W+1:2] : '0;
  assign o_sop    = fwd & sel_head[1];
  assign o_eop    = fwd & sel_head[0];
  assign o_grant  = fwd ? (NCH'(1) << grant_q) : '0;

`ifdef ETH_STREAM_MUX_STAT_EN
  logic [15:0] frame_cnt_q [NCH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) frame_cnt_q[k] <= '0;
    end else if (o_vld && i_rdy && o_eop) begin
      frame_cnt_q[grant_q] <= frame_cnt_q[grant_q] + 16'd1;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_cnt
    assign o_frame_cnt[k*16 +: 16] = frame_cnt_q[k];
  end
`else
  assign o_frame_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_stream_mux.sv
// Directed bench for eth_stream_mux (NCH=2, DATA_W=32, DEPTH_LOG2=2).
module tb_eth_stream_mux;
  localparam int DATA_W     = 32;
  localparam int MOD_W      = 2;
  localparam int NCH        = 2;
  localparam int DEPTH_LOG2 = 2;

`ifdef ETH_STREAM_MUX_STAT_EN
  localparam logic [31:0] FC_T1 = 32'h0000_0001;
`else
  localparam logic [31:0] FC_T1 = 32'h0000_0000;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NCH*DATA_W-1:0] i_data = '0;
  logic [NCH*MOD_W-1:0]  i_mod = '0;
  logic [NCH-1:0]        i_sop = '0;
  logic [NCH-1:0]        i_eop = '0;
  logic [NCH-1:0]        i_vld = '0;
  logic [NCH-1:0]        o_rdy;
  logic [DATA_W-1:0]     o_data;
  logic [MOD_W-1:0]      o_mod;
  logic                  o_sop;
  logic                  o_eop;
  logic                  o_vld;
  logic                  i_rdy = 1'b0;
  logic [NCH-1:0]        o_grant;
  logic [NCH-1:0]        o_drop;
  logic [NCH*16-1:0]     o_frame_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drop0 = 0;
  int drop1 = 0;
  int b0, b1;

  logic [31:0] q_data [$];
  logic [1:0]  q_grant [$];
  logic        q_sop [$];
  logic        q_eop [$];
  int          q_cyc [$];

  eth_stream_mux #(
    .DATA_W(DATA_W), .MOD_W(MOD_W), .NCH(NCH), .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_data(i_data), .i_mod(i_mod), .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
    .o_rdy(o_rdy),
    .o_data(o_data), .o_mod(o_mod), .o_sop(o_sop), .o_eop(o_eop), .o_vld(o_vld),
    .i_rdy(i_rdy), .o_grant(o_grant), .o_drop(o_drop), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every beat that will transfer at the coming rising edge.
  always @(negedge clk) begin
    if (o_vld && i_rdy) begin
      q_data.push_back(o_data);
      q_grant.push_back(o_grant);
      q_sop.push_back(o_sop);
      q_eop.push_back(o_eop);
      q_cyc.push_back(cyc);
    end
    if (o_drop[0]) drop0 <= drop0 + 1;
    if (o_drop[1]) drop1 <= drop1 + 1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int ch, input logic [31:0] d, input logic sop,
                          input logic eop, input logic [1:0] m);
    i_vld[ch] = 1'b1;
    i_data[ch*DATA_W +: DATA_W] = d;
    i_mod[ch*MOD_W +: MOD_W] = m;
    i_sop[ch] = sop;
    i_eop[ch] = eop;
  endtask

  task automatic clr();
    i_vld = '0;
    i_sop = '0;
    i_eop = '0;
  endtask

  task automatic qclear();
    q_data.delete();
    q_grant.delete();
    q_sop.delete();
    q_eop.delete();
    q_cyc.delete();
  endtask

  function automatic logic [31:0] qd(input int i);
    return (i < q_data.size()) ? q_data[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [1:0] qg(input int i);
    return (i < q_grant.size()) ? q_grant[i] : 2'bxx;
  endfunction

  initial begin
    // ---- reset state ----
    tick();
    tick();
    chk("rst_vld", o_vld, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_drop", o_drop, 0);
    chk("rst_fcnt", o_frame_cnt, 0);
    chk("rst_rdy", o_rdy, 2'b11);
    chk("rst_data", {o_data, o_mod, o_sop, o_eop}, 0);
    rst_n = 1'b1;
    i_rdy = 1'b1;
    tick();

    // ---- single 4-beat packet on ch0 ----
    set_beat(0, 32'h11, 1, 0, 2'd0);
    tick();
    chk("t1_vld_lat1", o_vld, 0);
    set_beat(0, 32'h22, 0, 0, 2'd0);
    tick();
    chk("t1_vld_lat2", o_vld, 1);
    chk("t1_d0", o_data, 32'h11);
    chk("t1_sop0", o_sop, 1);
    chk("t1_grant", o_grant, 2'b01);
    set_beat(0, 32'h33, 0, 0, 2'd0);
    tick();
    chk("t1_d1", o_data, 32'h22);
    chk("t1_sop1", o_sop, 0);
    set_beat(0, 32'h44, 0, 1, 2'd3);
    tick();
    chk("t1_d2", o_data, 32'h33);
    chk("t1_eop2", o_eop, 0);
    clr();
    tick();
    chk("t1_d3", o_data, 32'h44);
    chk("t1_eop3", o_eop, 1);
    chk("t1_mod3", o_mod, 2'd3);
    tick();
    chk("t1_idle_vld", o_vld, 0);
    chk("t1_idle_grant", o_grant, 0);
    chk("t1_fcnt", o_frame_cnt, FC_T1);

    // ---- two channels, three packets each, loaded right after reset ----
    rst_n = 1'b0;
    i_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int p = 0; p < 3; p++) begin
      set_beat(0, 32'hA0 + p, 1, 1, 2'd0);
      set_beat(1, 32'hB0 + p, 1, 1, 2'd0);
      tick();
    end
    clr();
    tick();
    qclear();
    i_rdy = 1'b1;
    repeat (14) tick();
    chk("t2_count", q_data.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_data%0d", i), qd(i), (i % 2 == 0) ? 32'hA0 + i / 2 : 32'hB0 + i / 2);
      chk($sformatf("t2_grant%0d", i), qg(i), (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    for (int i = 1; i < 6 && i < q_cyc.size(); i++) begin
      chk($sformatf("t2_gap%0d", i), q_cyc[i] - q_cyc[i-1], 2);
    end

    // ---- sink stalls 1,0,0,1 during a packet ----
    i_rdy = 1'b0;
    set_beat(0, 32'h51, 1, 0, 2'd0);
    tick();
    set_beat(0, 32'h52, 0, 0, 2'd0);
    tick();
    set_beat(0, 32'h53, 0, 0, 2'd0);
    tick();
    set_beat(0, 32'h54, 0, 1, 2'd2);
    tick();
    clr();
    tick();
    qclear();
    chk("t3_head", o_data, 32'h51);
    i_rdy = 1'b1;
    tick();
    i_rdy = 1'b0;
    chk("t3_stall_a", o_data, 32'h52);
    tick();
    chk("t3_stall_b", o_data, 32'h52);
    chk("t3_stall_vld", o_vld, 1);
    tick();
    chk("t3_stall_c", o_data, 32'h52);
    i_rdy = 1'b1;
    repeat (5) tick();
    chk("t3_count", q_data.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_data%0d", i), qd(i), 32'h51 + i);

    // ---- orphans on ch1 then a good packet ----
    qclear();
    b0 = drop0;
    b1 = drop1;
    set_beat(1, 32'hE1, 0, 0, 2'd0);
    tick();
    chk("t4_drop_a", o_drop, 2'b10);
    set_beat(1, 32'hE2, 0, 0, 2'd0);
    tick();
    chk("t4_drop_b", o_drop, 2'b10);
    set_beat(1, 32'hC1, 1, 0, 2'd0);
    tick();
    chk("t4_drop_c", o_drop, 2'b00);
    set_beat(1, 32'hC2, 0, 0, 2'd0);
    tick();
    set_beat(1, 32'hC3, 0, 1, 2'd1);
    tick();
    clr();
    repeat (6) tick();
    chk("t4_drops1", drop1 - b1, 2);
    chk("t4_drops0", drop0 - b0, 0);
    chk("t4_count", q_data.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t4_data%0d", i), qd(i), 32'hC1 + i);
    chk("t4_sop", (q_sop.size() > 0) ? q_sop[0] : 1'bx, 1);
    chk("t4_eop", (q_eop.size() > 2) ? q_eop[2] : 1'bx, 1);
    chk("t4_grant", qg(0), 2'b10);

    // ---- fill a 4-deep FIFO with 5 beats while the sink is stalled ----
    qclear();
    i_rdy = 1'b0;
    set_beat(0, 32'hD1, 1, 0, 2'd0);
    tick();
    for (int i = 2; i <= 4; i++) begin
      set_beat(0, 32'hD0 + i, 0, 0, 2'd0);
      tick();
    end
    set_beat(0, 32'hD5, 0, 1, 2'd0);
    chk("t5_full", o_rdy[0], 0);
    tick();
    chk("t5_hold", o_rdy[0], 0);
    i_rdy = 1'b1;
    chk("t5_pop_full", o_rdy[0], 0);
    tick();
    chk("t5_space", o_rdy[0], 1);
    tick();
    clr();
    repeat (8) tick();
    chk("t5_count", q_data.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t5_data%0d", i), qd(i), 32'hD1 + i);

    // ---- reset in the middle of a ch1 packet ----
    set_beat(1, 32'hF1, 1, 0, 2'd0);
    tick();
    set_beat(1, 32'hF2, 0, 0, 2'd0);
    tick();
    set_beat(1, 32'hF3, 0, 0, 2'd0);
    tick();
    chk("t6_beat2", o_data, 32'hF2);
    clr();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", o_vld, 0);
    chk("t6_rst_grant", o_grant, 0);
    chk("t6_rst_rdy", o_rdy, 2'b11);
    tick();
    rst_n = 1'b1;
    qclear();
    set_beat(0, 32'h61, 1, 1, 2'd0);
    set_beat(1, 32'h71, 1, 1, 2'd0);
    tick();
    clr();
    repeat (8) tick();
    chk("t6_count", q_data.size(), 2);
    chk("t6_first", qd(0), 32'h61);
    chk("t6_first_grant", qg(0), 2'b01);
    chk("t6_second", qd(1), 32'h71);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_stream_mux.md
ETH_STREAM_MUX -- requirements
Module: eth_stream_mux

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stream data width in bits.
REQ-002 SHALL have parameter MOD_W, default 2, empty-byte modulo width on the last beat.
REQ-003 SHALL have parameter NCH, default 2, number of input channels (2..8).
REQ-004 SHALL have parameter DEPTH_LOG2, default 6, log2 of per-channel FIFO depth in beats.
REQ-005 SHALL have port clk  input  1  single clock for all logic.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port i_data  input  NCH*DATA_W  input data; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port i_mod  input  NCH*MOD_W  input modulo per channel, packed the same way as i_data.
REQ-009 SHALL have ports i_sop / i_eop / i_vld  input  NCH each  per-channel start-of-packet, end-of-packet and valid.
REQ-010 SHALL have port o_rdy  output  NCH  per-channel ready, equal to FIFO not full.
REQ-011 SHALL have ports o_data / o_mod / o_sop / o_eop  output  DATA_W / MOD_W / 1 / 1  merged stream towards the MAC tx FIFO side.
REQ-012 SHALL have port o_vld  output  1  merged stream valid.
REQ-013 SHALL have port i_rdy  input  1  sink ready (MAC ff_tx_rdy).
REQ-014 SHALL have port o_grant  output  NCH  one-hot channel currently being forwarded; all zero when idle.
REQ-015 SHALL have port o_drop  output  NCH  one-cycle pulse for each orphan beat discarded per channel.
REQ-016 SHALL have port o_frame_cnt  output  NCH*16  per-channel forwarded-frame counters.

Function
REQ-017 Each channel SHALL buffer {data, mod, sop, eop} in a show-ahead FIFO of 2^DEPTH_LOG2 entries.
REQ-018 Input beat accepted iff i_vld[k] & o_rdy[k]; i_vld while full SHALL be ignored with no overwrite.
REQ-019 Written beat SHALL appear at the FIFO head on the next cycle.
REQ-020 Arbiter SHALL have two states: IDLE and FWD.
REQ-021 IDLE: SHALL scan round-robin starting at last_grant+1 mod NCH for a non-empty channel whose head has sop=1.
- On a match, SHALL register the grant and enter FWD.
- o_vld SHALL rise on the next cycle (first beat appears 2 cycles after its input write at the earliest).
REQ-022 IDLE: a non-empty channel whose head has sop=0 is an orphan.
- One orphan beat SHALL be popped per cycle on every such channel, with o_drop[k] pulsed.
- Dropping SHALL NOT block grant to other channels.
REQ-023 FWD: o_vld SHALL equal the granted FIFO not-empty; outputs SHALL be the granted FIFO head; pop iff o_vld & i_rdy.
REQ-024 FWD: on transfer of a beat with eop=1, SHALL return to IDLE and update last_grant.
- One idle bubble SHALL separate consecutive packets.
REQ-025 FWD: sop=1 beats before eop SHALL be forwarded unchanged; no reframing.
REQ-026 FWD: granted FIFO empty mid-packet SHALL deassert o_vld and hold the grant until eop.
REQ-027 Outputs SHALL hold stable while o_vld=1 and i_rdy=0.
REQ-028 Simultaneous write and pop on one FIFO SHALL both take effect with occupancy unchanged.
REQ-029 Full FIFO popped in a cycle SHALL still report o_rdy=0 in that cycle; the write is accepted next cycle.
REQ-030 o_grant SHALL be one-hot in FWD and zero in IDLE.

Reset
REQ-031 On rst_n=0, SHALL asynchronously clear:
- all FIFO pointers and occupancy;
- state to IDLE;
- last_grant to NCH-1, so channel 0 wins first.
REQ-032 During reset SHALL hold o_vld=0, o_grant=0, o_drop=0, o_frame_cnt=0 and o_rdy=all ones.
- o_data, o_mod, o_sop and o_eop SHALL be 0.
REQ-033 Reset asserted mid-packet SHALL discard the partial packet; no resumption after release.

Configuration
REQ-034 Macro ETH_STREAM_MUX_STAT_EN defined: o_frame_cnt[k] SHALL increment by 1 on every transferred eop beat of channel k, wrapping 0xFFFF->0.
REQ-035 Macro ETH_STREAM_MUX_STAT_EN undefined: o_frame_cnt SHALL be constant 0, with no counter flops.

Verification
REQ-036 Single packet ch0, 4 beats 0x11..0x44, i_rdy=1 -> o_vld high 2 cycles after first write; 4 beats in order; o_eop on 0x44; o_grant=01; o_frame_cnt[0]=1.
REQ-037 Ch0 and ch1 each hold 3 packets at reset release -> order ch0,ch1,ch0,ch1,ch0,ch1 with one bubble between packets.
REQ-038 i_rdy toggles 1,0,0,1 during a packet -> each beat delivered exactly once; outputs stable across stalls.
REQ-039 Ch1 receives 2 beats without sop, then a valid packet -> o_drop[1] pulses twice, then the packet is forwarded intact.
REQ-040 DEPTH_LOG2=2, 5 back-to-back writes with i_rdy=0 -> o_rdy[0] low after 4 beats, 5th beat held by source, none lost after i_rdy=1.
REQ-041 Reset asserted in beat 2 of a 4-beat packet -> o_vld=0 at once; after release the next valid packet is forwarded first from ch0.
